// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR owner running the imem request/valid handshake.
// Applies at most one Jump/Branch redirect per fetched instruction while holding the IR.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, pc4_q, pc4_d;
    logic        vld_q, vld_d, err_q, err_d, rdone_q, rdone_d;
    logic [7:0]  wait_q, wait_d;
    logic        fetched, timeout, redirect;
    logic [31:0] jump_tgt, br_tgt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            pc4_q   <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdone_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            rdone_q <= rdone_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fetch_en ? REQ : IDLE;
            REQ:     state_d = imem_valid ? HOLD : timeout ? IDLE : REQ;
            HOLD:    state_d = fetch_en ? REQ : HOLD;
            default: state_d = IDLE;
        endcase
    end

    // Redirect targets are formed from the held IR and the address following it.
    always_comb begin
        fetched  = (state_q == REQ) && imem_valid;
        timeout  = !imem_valid && (wait_q + 8'd1 == MAX_W);
        redirect = (state_q == HOLD) && !rdone_q && (Jump || (Branch && Zero));
        jump_tgt = {pc4_q[31:28], ir_q[25:0], 2'b00};
        br_tgt   = pc4_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        pc_d     = fetched ? pc_q + 32'd4 : redirect ? (Jump ? jump_tgt : br_tgt) : pc_q;
        pc4_d    = fetched ? pc_q + 32'd4 : pc4_q;
        ir_d     = fetched ? imem_rdata : ir_q;
        vld_d    = fetched || (vld_q && !((state_q == HOLD) && fetch_en));
        rdone_d  = fetched ? 1'b0 : (rdone_q || redirect);
        err_d    = err_q || ((state_q == REQ) && timeout);
        wait_d   = (state_q == REQ) ? wait_q + 8'd1 : 8'd0;
    end

    always_comb begin
        imem_req    = (state_q == REQ);
        imem_addr   = pc_q;
        instr       = ir_q;
        instr_valid = vld_q;
        pc          = pc_q;
        pc_plus4    = pc4_q;
        fetch_err   = err_q;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scenario tasks with a scoreboard of expected fetch results.
// Two extra instances (wrapping and high RESET_PC) cover the wrap and jump scenarios.
module tb_instr_fetch_unit;
    logic        clk = 0, rst = 0, rst2 = 0;
    logic        fetch_en = 0, fetch_en2 = 0, Branch = 0, Jump = 0, Zero = 0, imem_valid = 0;
    logic [31:0] imem_rdata = 0;
    logic        req_a, iv_a, err_a, req_b, iv_b, err_b, req_c, iv_c, err_c;
    logic [31:0] addr_a, instr_a, pc_a, p4_a, addr_b, instr_b, pc_b, p4_b, addr_c, instr_c, pc_c, p4_c;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] p4;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_req(req_a), .imem_addr(addr_a),
        .instr(instr_a), .instr_valid(iv_a), .pc(pc_a), .pc_plus4(p4_a), .fetch_err(err_a));

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst2), .fetch_en(fetch_en2), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_req(req_b), .imem_addr(addr_b),
        .instr(instr_b), .instr_valid(iv_b), .pc(pc_b), .pc_plus4(p4_b), .fetch_err(err_b));

    instr_fetch_unit #(.RESET_PC(32'h1000_0000)) dut_hi (
        .clk(clk), .rst(rst2), .fetch_en(fetch_en2), .Branch(Branch), .Jump(Jump), .Zero(Zero),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_req(req_c), .imem_addr(addr_c),
        .instr(instr_c), .instr_valid(iv_c), .pc(pc_c), .pc_plus4(p4_c), .fetch_err(err_c));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(output logic req, output logic [31:0] addr);
        fetch_en = 1;
        tick();
        fetch_en = 0;
        req  = req_a;
        addr = addr_a;
    endtask

    task automatic complete(input logic [31:0] data, input int lat, input logic [31:0] from_pc);
        repeat (lat) tick();
        imem_valid = 1;
        imem_rdata = data;
        sb.push_back({data, from_pc + 32'd4, from_pc + 32'd4});
        tick();
        imem_valid = 0;
    endtask

    task automatic test_reset;
        rst = 0;
        tick();
        tick();
        total++; if (req_a !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", req_a); end
        total++; if (pc_a !== 32'd0) begin bad++; $display("FAIL rst_pc: got %h want 0", pc_a); end
        total++; if (instr_a !== 32'd0) begin bad++; $display("FAIL rst_instr: got %h want 0", instr_a); end
        total++; if ({iv_a, err_a} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {iv_a, err_a}); end
        total++; if (p4_a !== 32'd0) begin bad++; $display("FAIL rst_p4: got %h want 0", p4_a); end
        rst = 1;
        tick();
    endtask

    task automatic test_fetch;
        logic req;
        logic [31:0] addr;
        exp_t e;
        start(req, addr);
        total++; if (req !== 1'b1) begin bad++; $display("FAIL fetch_req: got %b want 1", req); end
        total++; if (addr !== 32'd0) begin bad++; $display("FAIL fetch_addr: got %h want 0", addr); end
        complete(32'h8C22_0004, 0, 32'd0);
        e = sb.pop_front();
        total++; if (instr_a !== e.instr) begin bad++; $display("FAIL fetch_instr: got %h want %h", instr_a, e.instr); end
        total++; if (iv_a !== 1'b1) begin bad++; $display("FAIL fetch_valid: got %b want 1", iv_a); end
        total++; if (pc_a !== e.pc) begin bad++; $display("FAIL fetch_pc: got %h want %h", pc_a, e.pc); end
        total++; if (p4_a !== e.p4) begin bad++; $display("FAIL fetch_p4: got %h want %h", p4_a, e.p4); end
        total++; if (req_a !== 1'b0) begin bad++; $display("FAIL hold_req: got %b want 0", req_a); end
    endtask

    task automatic test_branch;
        logic req;
        logic [31:0] addr;
        exp_t e;
        start(req, addr);
        total++; if (addr !== 32'd4) begin bad++; $display("FAIL br_addr: got %h want 4", addr); end
        complete(32'h1000_0003, 1, 32'd4);
        e = sb.pop_front();
        total++; if (p4_a !== e.p4) begin bad++; $display("FAIL br_p4: got %h want %h", p4_a, e.p4); end
        Branch = 1; Zero = 1; fetch_en = 1;
        tick();
        Branch = 0; Zero = 0; fetch_en = 0;
        total++; if (addr_a !== 32'd20) begin bad++; $display("FAIL br_taken_addr: got %h want 14", addr_a); end
        total++; if ({req_a, iv_a} !== 2'b10) begin bad++; $display("FAIL br_req_state: got %b want 10", {req_a, iv_a}); end
        fetch_en = 1;
        tick();
        fetch_en = 0;
        total++; if ({req_a, addr_a} !== {1'b1, 32'd20}) begin bad++; $display("FAIL req_ignores_en: got %b/%h want 1/14", req_a, addr_a); end
        complete(32'h1000_0003, 0, 32'd20);
        e = sb.pop_front();
        total++; if (pc_a !== e.pc) begin bad++; $display("FAIL br2_pc: got %h want %h", pc_a, e.pc); end
        Branch = 1; Zero = 0;
        tick();
        tick();
        Branch = 0;
        total++; if (pc_a !== e.pc) begin bad++; $display("FAIL br_not_taken: got %h want %h", pc_a, e.pc); end
    endtask

    task automatic test_timeout;
        logic req;
        logic [31:0] addr;
        exp_t e;
        start(req, addr);
        total++; if (addr !== 32'd24) begin bad++; $display("FAIL to_addr: got %h want 18", addr); end
        repeat (14) tick();
        total++; if ({req_a, err_a} !== 2'b10) begin bad++; $display("FAIL to_early: got %b want 10", {req_a, err_a}); end
        tick();
        total++; if ({req_a, err_a, iv_a} !== 3'b010) begin bad++; $display("FAIL to_flag: got %b want 010", {req_a, err_a, iv_a}); end
        total++; if (pc_a !== 32'd24) begin bad++; $display("FAIL to_pc: got %h want 18", pc_a); end
        start(req, addr);
        total++; if ({req, addr} !== {1'b1, 32'd24}) begin bad++; $display("FAIL retry_addr: got %b/%h want 1/18", req, addr); end
        complete(32'h2001_0005, 0, 32'd24);
        e = sb.pop_front();
        total++; if ({instr_a, pc_a} !== {e.instr, e.pc}) begin bad++; $display("FAIL retry_fetch: got %h/%h want %h/%h", instr_a, pc_a, e.instr, e.pc); end
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_a); end
    endtask

    task automatic test_reset_mid;
        logic req;
        logic [31:0] addr;
        start(req, addr);
        tick();
        tick();
        total++; if (req_a !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", req_a); end
        rst = 0;
        #1;
        total++; if (req_a !== 1'b0) begin bad++; $display("FAIL mid_async_req: got %b want 0", req_a); end
        total++; if ({pc_a, instr_a, p4_a} !== 96'd0) begin bad++; $display("FAIL mid_regs: got %h/%h/%h want 0", pc_a, instr_a, p4_a); end
        total++; if ({iv_a, err_a} !== 2'b00) begin bad++; $display("FAIL mid_flags: got %b want 00", {iv_a, err_a}); end
        tick();
        rst = 1;
        tick();
        imem_valid = 1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_valid = 0;
        tick();
        total++; if ({instr_a, iv_a, req_a} !== 34'd0) begin bad++; $display("FAIL late_valid: got %h/%b/%b want 0", instr_a, iv_a, req_a); end
    endtask

    task automatic test_wrap_jump;
        exp_t eb, ec;
        rst2 = 1;
        tick();
        fetch_en2 = 1;
        tick();
        fetch_en2 = 0;
        total++; if ({req_b, addr_b} !== {1'b1, 32'hFFFF_FFFC}) begin bad++; $display("FAIL wrap_addr: got %b/%h want 1/fffffffc", req_b, addr_b); end
        total++; if (addr_c !== 32'h1000_0000) begin bad++; $display("FAIL hi_addr: got %h want 10000000", addr_c); end
        imem_valid = 1;
        imem_rdata = 32'h0800_0010;
        sb.push_back({32'h0800_0010, 32'hFFFF_FFFC + 32'd4, 32'hFFFF_FFFC + 32'd4});
        sb.push_back({32'h0800_0010, 32'h1000_0004, 32'h1000_0004});
        tick();
        imem_valid = 0;
        eb = sb.pop_front();
        ec = sb.pop_front();
        total++; if ({pc_b, p4_b} !== {eb.pc, eb.p4}) begin bad++; $display("FAIL wrap_pc: got %h/%h want %h/%h", pc_b, p4_b, eb.pc, eb.p4); end
        total++; if ({instr_c, p4_c, iv_c} !== {ec.instr, ec.p4, 1'b1}) begin bad++; $display("FAIL hi_fetch: got %h/%h/%b want %h/%h/1", instr_c, p4_c, iv_c, ec.instr, ec.p4); end
        total++; if (instr_a !== 32'd0) begin bad++; $display("FAIL idle_ignores_valid: got %h want 0", instr_a); end
        Jump = 1; Branch = 1; Zero = 1;
        tick();
        total++; if (pc_c !== 32'h1000_0040) begin bad++; $display("FAIL jump_wins: got %h want 10000040", pc_c); end
        total++; if (pc_b !== 32'h0000_0040) begin bad++; $display("FAIL wrap_jump: got %h want 40", pc_b); end
        tick();
        tick();
        Jump = 0; Branch = 0; Zero = 0;
        total++; if (pc_c !== 32'h1000_0040) begin bad++; $display("FAIL jump_once: got %h want 10000040", pc_c); end
        total++; if ({err_b, err_c} !== 2'b00) begin bad++; $display("FAIL wrap_err: got %b want 00", {err_b, err_c}); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_timeout();
        test_reset_mid();
        test_wrap_jump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
